multicycle_controller: RTL

Parametrised next-generation control unit for the 16-bit CPU. It fetches over a ready/valid instruction-memory handshake, so the block works with wait-stated memories. It decodes 16-bit instructions and drives the register-file, data-memory and ALU controls to the datapath. Compared with the fixed single-ROM controller it adds configurable PC and address widths, JMP/JZ control flow, a zero flag, and a resumable HALT.

---
 rtl/multicycle_controller.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle control unit for the 16-bit CPU: ready/valid instruction fetch, decode, registered datapath controls.
// Optional build macro ILLEGAL_TRAP_EN: opcodes 8..15 enter a reset-only TRAP state instead of decoding as NOOP.
module multicycle_controller #(
    parameter int PC_W      = 7,
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    output logic [PC_W-1:0]      IMem_Addr,
    output logic                 IMem_Rd,
    input  logic                 IMem_Rdy,
    input  logic [15:0]          IMem_Data,
    input  logic                 ALU_Zero,
    input  logic                 Resume,
    output logic [PC_W-1:0]      PC_Out,
    output logic [15:0]          IR_Out,
    output logic [3:0]           OutState,
    output logic [3:0]           NextState,
    output logic [D_ADDR_W-1:0]  D_Addr,
    output logic                 D_Wr,
    output logic                 RF_s,
    output logic                 RF_W_en,
    output logic [RF_ADDR_W-1:0] RF_Ra_Addr,
    output logic [RF_ADDR_W-1:0] RF_Rb_Addr,
    output logic [RF_ADDR_W-1:0] RF_W_Addr,
    output logic [2:0]           ALU_s0,
    output logic                 Halted,
    output logic                 Illegal
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_JMP    = 4'd9,
        S_JZ     = 4'd10,
        S_NOOP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t UNDEF_DEST = S_TRAP;
`else
    localparam state_t UNDEF_DEST = S_NOOP;
`endif

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                z_q, z_d;

    logic                imem_rd_q, imem_rd_d;
    logic [PC_W-1:0]     imem_addr_q, imem_addr_d;
    logic [D_ADDR_W-1:0] d_addr_q, d_addr_d;
    logic                d_wr_q, d_wr_d;
    logic                rf_s_q, rf_s_d;
    logic                rf_w_en_q, rf_w_en_d;
    logic [RF_ADDR_W-1:0] ra_q, ra_d;
    logic [RF_ADDR_W-1:0] rb_q, rb_d;
    logic [RF_ADDR_W-1:0] w_q, w_d;
    logic [2:0]          alu_s0_q, alu_s0_d;
    logic                halted_q, halted_d;
`ifdef ILLEGAL_TRAP_EN
    logic                illegal_q, illegal_d;
`endif

    logic [3:0]          opcode_s;
    logic [PC_W-1:0]     target_s;

    assign opcode_s = ir_q[15:12];
    assign target_s = ir_q[PC_W-1:0];

    // Next-state, PC, IR and zero-flag computation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        z_d     = z_q;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                if (IMem_Rdy) begin
                    ir_d    = IMem_Data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    OP_JMP:   state_d = S_JMP;
                    OP_JZ:    state_d = S_JZ;
                    default:  state_d = UNDEF_DEST;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD, S_SUB: begin
                z_d     = ALU_Zero;
                state_d = S_FETCH;
            end
            S_JMP: begin
                pc_d    = target_s;
                state_d = S_FETCH;
            end
            S_JZ: begin
                if (z_q) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                state_d = S_FETCH;
            end
            S_NOOP: state_d = S_FETCH;
            // PC already points past the HALT, so resuming simply refetches from it
            S_HALT: begin
                if (Resume) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_HALT;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_INIT;
        endcase
    end

    // Control outputs for the state being entered, so they register in step with it
    always_comb begin
        imem_rd_d   = 1'b0;
        imem_addr_d = '0;
        d_addr_d    = '0;
        d_wr_d      = 1'b0;
        rf_s_d      = 1'b0;
        rf_w_en_d   = 1'b0;
        ra_d        = '0;
        rb_d        = '0;
        w_d         = '0;
        alu_s0_d    = 3'd0;
        halted_d    = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = 1'b0;
`endif
        case (state_d)
            S_FETCH: begin
                imem_rd_d   = 1'b1;
                imem_addr_d = pc_d;
            end
            S_LOAD_A: begin
                d_addr_d = ir_d[D_ADDR_W+3:4];
                rf_s_d   = 1'b1;
            end
            S_LOAD_B: begin
                d_addr_d  = ir_d[D_ADDR_W+3:4];
                rf_s_d    = 1'b1;
                rf_w_en_d = 1'b1;
                w_d       = ir_d[3:0];
            end
            S_STORE: begin
                d_addr_d = ir_d[D_ADDR_W+3:4];
                d_wr_d   = 1'b1;
                ra_d     = ir_d[3:0];
            end
            S_ADD, S_SUB: begin
                rf_w_en_d = 1'b1;
                ra_d      = ir_d[11:8];
                rb_d      = ir_d[7:4];
                w_d       = ir_d[3:0];
                alu_s0_d  = (state_d == S_ADD) ? 3'd1 : 3'd2;
            end
            S_HALT: halted_d = 1'b1;
            S_TRAP: begin
                halted_d  = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                illegal_d = 1'b1;
`endif
            end
            default: imem_rd_d = 1'b0;
        endcase
    end

    // State, architectural registers and registered control outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= S_INIT;
            pc_q        <= '0;
            ir_q        <= 16'h0000;
            z_q         <= 1'b0;
            imem_rd_q   <= 1'b0;
            imem_addr_q <= '0;
            d_addr_q    <= '0;
            d_wr_q      <= 1'b0;
            rf_s_q      <= 1'b0;
            rf_w_en_q   <= 1'b0;
            ra_q        <= '0;
            rb_q        <= '0;
            w_q         <= '0;
            alu_s0_q    <= 3'd0;
            halted_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            z_q         <= z_d;
            imem_rd_q   <= imem_rd_d;
            imem_addr_q <= imem_addr_d;
            d_addr_q    <= d_addr_d;
            d_wr_q      <= d_wr_d;
            rf_s_q      <= rf_s_d;
            rf_w_en_q   <= rf_w_en_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            w_q         <= w_d;
            alu_s0_q    <= alu_s0_d;
            halted_q    <= halted_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign IMem_Rd    = imem_rd_q;
    assign IMem_Addr  = imem_addr_q;
    assign PC_Out     = pc_q;
    assign IR_Out     = ir_q;
    assign OutState   = state_q;
    assign NextState  = state_d;
    assign D_Addr     = d_addr_q;
    assign D_Wr       = d_wr_q;
    assign RF_s       = rf_s_q;
    assign RF_W_en    = rf_w_en_q;
    assign RF_Ra_Addr = ra_q;
    assign RF_Rb_Addr = rb_q;
    assign RF_W_Addr  = w_q;
    assign ALU_s0     = alu_s0_q;
    assign Halted     = halted_q;
`ifdef ILLEGAL_TRAP_EN
    assign Illegal    = illegal_q;
`else
    assign Illegal    = 1'b0;
`endif

endmodule
